// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV32I definitions for the instruction loader and the opcode decoder:
//   - opcode constants for the supported base-ISA major opcodes
//   - loader_state_t : boot-loader FSM states
//   - op_supported() : true when bits[6:0] name a supported opcode
// -----------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_L     = 7'b0000011;

   typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERROR} loader_state_t;

   function automatic logic op_supported(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_B, OP_S, OP_AUIPC,
         OP_LUI, OP_JAL, OP_JALR, OP_L: return 1'b1;
         default:                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler
// Packs accepted bytes into little-endian 32-bit words (first byte -> [7:0]).
// Ports:
//   i_clk, i_rst     clock, async active-high reset
//   i_clear          restart at byte 0 (new load)
//   i_valid, i_byte  one accepted byte
//   o_word           assembled word, valid together with o_word_ready
//   o_word_ready     1 when i_byte is the 4th byte of a word (combinational)
// -----------------------------------------------------------------------------
module word_assembler
   import riscv_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_ready
);

   logic [1:0]  r_idx;
   logic [23:0] r_sh;   // three earlier bytes, oldest in [7:0]

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idx <= '0;
         r_sh  <= '0;
      end else if (i_clear) begin
         r_idx <= '0;
      end else if (i_valid) begin
         r_idx <= r_idx + 2'd1;
         r_sh  <= {i_byte, r_sh[23:8]};
      end
   end

   // The 4th byte is combined straight from the input so the word is ready
   // in the same cycle it completes.
   assign o_word       = {i_byte, r_sh};
   assign o_word_ready = i_valid && (r_idx == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
// Boot-time program loader. Frame: LEN_LO, LEN_HI (word count N), then N*4
// little-endian data bytes. Words are written to imem from address 0 and the
// CPU is held in reset until the load finishes.
// Optional: LOADER_OPCHECK_EN checks each word's opcode; an unsupported opcode
// suppresses that write and aborts the load into ERROR.
// Ports:
//   clk, rst            clock, async active-high reset
//   start               begin a load (honoured in IDLE/DONE/ERROR only)
//   rx_data/valid/ready byte stream handshake
//   imem_we/addr/wdata  instruction memory write port
//   cpu_hold            CPU reset hold, low only in DONE
//   done, err           load outcome levels
//   words_rx            words written in the current load
// -----------------------------------------------------------------------------
module instr_loader
   import riscv_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              err,
   output logic [15:0]       words_rx
);

   loader_state_t     r_state, w_next;
   logic [15:0]       r_len;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [15:0]       r_words;

   logic        w_xfer, w_start_ok, w_data_byte, w_last, w_op_ok;
   logic [15:0] w_len_new;
   logic [31:0] w_word;
   logic        w_word_ready;

   assign rx_ready    = (r_state == LEN0) || (r_state == LEN1) || (r_state == DATA);
   assign w_xfer      = rx_valid && rx_ready;
   assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERROR));
   assign w_data_byte = w_xfer && (r_state == DATA);
   assign w_len_new   = {rx_data, r_len[7:0]};
   // The write pulse of word N closes the load.
   assign w_last      = r_we && (r_words == r_len - 16'd1);

   word_assembler u_asm (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_clear      (w_start_ok),
      .i_valid      (w_data_byte),
      .i_byte       (rx_data),
      .o_word       (w_word),
      .o_word_ready (w_word_ready)
   );

`ifdef LOADER_OPCHECK_EN
   assign w_op_ok = op_supported(w_word[6:0]);
`else
   assign w_op_ok = 1'b1;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE, ERROR: if (start) w_next = LEN0;
         LEN0:              if (w_xfer) w_next = LEN1;
         LEN1: begin
            if (w_xfer) begin
               if (w_len_new == 16'd0)                      w_next = DONE;
               else if (32'(w_len_new) > 32'(MAX_WORDS))    w_next = ERROR;
               else                                         w_next = DATA;
            end
         end
         DATA: begin
            if (w_word_ready && !w_op_ok) w_next = ERROR;
            else if (w_last)              w_next = DONE;
         end
         default:                         w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_len   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_words <= '0;
      end else begin
         r_state <= w_next;
         r_we    <= w_word_ready && w_op_ok;
         if (w_xfer && r_state == LEN0) r_len[7:0]  <= rx_data;
         if (w_xfer && r_state == LEN1) r_len[15:8] <= rx_data;
         if (w_word_ready)              r_wdata     <= w_word;
         if (w_start_ok) begin
            r_words <= '0;
            r_addr  <= '0;
         end else if (r_we) begin
            r_words <= r_words + 16'd1;
            // Address stays on the final word so N == MAX_WORDS cannot wrap.
            if (!w_last) r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

   assign imem_we    = r_we;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign words_rx   = r_words;
   assign done       = (r_state == DONE);
   assign err        = (r_state == ERROR);
   assign cpu_hold   = (r_state != DONE);

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
   localparam int ADDR_W = 10;
   localparam int MAXW   = 1024;
   localparam int P_IDLE = 0, P_LOAD = 1, P_DONE = 2, P_ERR = 3;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic rx_ready, imem_we, cpu_hold, done, err;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0] imem_wdata;
   logic [15:0] words_rx;

   always #5 clk = ~clk;

   instr_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAXW)) dut (
      .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .done(done), .err(err), .words_rx(words_rx));

   logic [6:0] ops [9] = '{7'h33, 7'h13, 7'h63, 7'h23, 7'h17, 7'h37, 7'h6F, 7'h67, 7'h03};

   int n_chk, n_err;
   bit cmp_en = 1'b0, stalled = 1'b0;
   int inject_at = -1;
   logic [31:0] fw[$];

   // ---------------- behavioural model: counts bytes of the frame ----------------
   int m_phase, m_nb, m_n, m_written, m_old;
   bit m_pend, m_acc;
   logic [31:0] m_wd, m_w;
   logic [7:0] m_bytes[$];

   function automatic bit op_bad(input logic [31:0] w);
`ifdef LOADER_OPCHECK_EN
      return !(w[6:0] inside {7'h33, 7'h13, 7'h63, 7'h23, 7'h17, 7'h37, 7'h6F, 7'h67, 7'h03});
`else
      return 1'b0;
`endif
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = P_IDLE; m_nb = 0; m_n = 0; m_written = 0; m_pend = 0; m_wd = 0;
         m_bytes.delete();
      end else begin
         m_old = m_phase;
         m_acc = rx_valid && (m_old == P_LOAD);
         if (m_pend) begin
            m_pend = 0;
            m_written++;
            if (m_written == m_n) m_phase = P_DONE;
         end
         if (m_acc) begin
            m_bytes.push_back(rx_data);
            m_nb++;
            if (m_nb == 2) begin
               m_n = {24'd0, m_bytes[1], m_bytes[0]};
               if (m_n == 0) m_phase = P_DONE;
               else if (m_n > MAXW) m_phase = P_ERR;
            end else if (m_nb > 2 && (m_nb - 2) % 4 == 0) begin
               m_w  = {m_bytes[m_nb-1], m_bytes[m_nb-2], m_bytes[m_nb-3], m_bytes[m_nb-4]};
               m_wd = m_w;
               if (op_bad(m_w)) m_phase = P_ERR;
               else             m_pend  = 1;
            end
         end
         if (start && m_old != P_LOAD) begin
            m_phase = P_LOAD; m_nb = 0; m_n = 0; m_written = 0; m_pend = 0;
            m_bytes.delete();
         end
      end
   end

   // ---------------- write log ----------------
   int wa[$];
   logic [31:0] wd[$];
   always @(negedge clk) begin
      if (!rst && imem_we) begin
         wa.push_back(int'(imem_addr));
         wd.push_back(imem_wdata);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      w[6:0] = ops[$urandom_range(0, 8)];
      return w;
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      bit acc;
      int tries;
      acc = 0; tries = 0;
      if (stalled) return;
      while (!acc) begin
         if (tries > 200) begin
            chk("rx_handshake_timeout", 32'(tries), 32'd0);
            stalled = 1'b1;
            rx_valid = 1'b0;
            return;
         end
         rx_valid = ($urandom_range(0, 99) >= gap_pct);
         rx_data  = rx_valid ? b : 8'($urandom);
         @(negedge clk);
         acc = rx_valid && rx_ready;
         @(posedge clk); #1;
         tries++;
      end
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int len, input int gap);
      logic [7:0] b[$];
      logic [31:0] w;
      b.push_back(len[7:0]);
      b.push_back(len[15:8]);
      foreach (fw[i]) begin
         w = fw[i];
         b.push_back(w[7:0]); b.push_back(w[15:8]); b.push_back(w[23:16]); b.push_back(w[31:24]);
      end
      for (int i = 0; i < b.size(); i++) begin
         if (i == inject_at) pulse_start();
         send_byte(b[i], gap);
      end
      rx_valid = 1'b0;
   endtask

   task automatic wait_end();
      int c;
      c = 0;
      while (!(done || err) && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      if (c >= 50) chk("wait_end_timeout", 32'(c), 32'd0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic check_writes(input string nm, input int base, input int nexp);
      int n, bad;
      n = wa.size() - base;
      bad = 0;
      chk({nm, "_count"}, 32'(n), 32'(nexp));
      for (int i = 0; i < n && i < nexp && i < fw.size(); i++)
         if (wa[base+i] != i || wd[base+i] !== fw[i]) bad++;
      chk({nm, "_data"}, 32'(bad), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- main ----------------
   initial begin
      int base, base_a;
      int bad;
      n_chk = 0; n_err = 0;

      fork
         forever begin
            @(negedge clk);
            if (!rst && cmp_en) begin
               chk("rx_ready", 32'(rx_ready), 32'(m_phase == P_LOAD));
               chk("imem_we",  32'(imem_we),  32'(m_pend));
               if (m_pend) chk("imem_wdata", imem_wdata, m_wd);
               chk("imem_addr", 32'(imem_addr),
                   32'((m_phase == P_DONE && m_written > 0) ? m_written - 1 : m_written));
               chk("words_rx", 32'(words_rx), 32'(m_written));
               chk("done",     32'(done),     32'(m_phase == P_DONE));
               chk("err",      32'(err),      32'(m_phase == P_ERR));
               chk("cpu_hold", 32'(cpu_hold), 32'(m_phase != P_DONE));
            end
         end
      join_none

      // reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rx_ready", 32'(rx_ready), 0);
      chk("rst_we",       32'(imem_we), 0);
      chk("rst_addr",     32'(imem_addr), 0);
      chk("rst_wdata",    imem_wdata, 0);
      chk("rst_hold",     32'(cpu_hold), 1);
      chk("rst_done",     32'(done), 0);
      chk("rst_err",      32'(err), 0);
      chk("rst_words",    32'(words_rx), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 1: two-word program
      pulse_start();
      fw = '{32'h00100513, 32'h0000006F};
      base = wa.size();
      send_frame(2, 0);
      wait_end();
      check_writes("t1", base, 2);
      chk("t1_w0", (wd.size() > base) ? wd[base] : 32'hxxxxxxxx, 32'h00100513);
      chk("t1_w1", (wd.size() > base + 1) ? wd[base+1] : 32'hxxxxxxxx, 32'h0000006F);
      chk("t1_done", 32'(done), 1);
      chk("t1_hold", 32'(cpu_hold), 0);
      chk("t1_words", 32'(words_rx), 2);
      chk("t1_addr", 32'(imem_addr), 1);

      // 2: zero-length frame
      pulse_start();
      fw.delete();
      base = wa.size();
      send_frame(0, 0);
      wait_end();
      check_writes("t2", base, 0);
      chk("t2_done", 32'(done), 1);

      // 3: over-long frame
      pulse_start();
      base = wa.size();
      send_frame(16'h0401, 0);
      wait_end();
      check_writes("t3", base, 0);
      chk("t3_err", 32'(err), 1);
      chk("t3_hold", 32'(cpu_hold), 1);
      chk("t3_ready", 32'(rx_ready), 0);

      // 4: gap-free vs gappy with a stray start mid-DATA
      fw.delete();
      for (int i = 0; i < 8; i++) fw.push_back(rand_word());
      pulse_start();
      base_a = wa.size();
      send_frame(8, 0);
      wait_end();
      check_writes("t4a", base_a, 8);
      pulse_start();
      base = wa.size();
      inject_at = 10;
      send_frame(8, 40);
      inject_at = -1;
      wait_end();
      check_writes("t4b", base, 8);
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (wa.size() < base + 8 || wd[base_a+i] !== wd[base+i]) bad++;
      chk("t4_same_image", 32'(bad), 0);
      chk("t4_done", 32'(done), 1);

      // 5: second word has an unsupported opcode
      fw = '{32'h00100513, 32'hFFFFFFFF};
      pulse_start();
      base = wa.size();
      send_frame(2, 10);
      wait_end();
`ifdef LOADER_OPCHECK_EN
      check_writes("t5", base, 1);
      chk("t5_err", 32'(err), 1);
      chk("t5_words", 32'(words_rx), 1);
`else
      check_writes("t5", base, 2);
      chk("t5_done", 32'(done), 1);
      chk("t5_words", 32'(words_rx), 2);
`endif

      // 6: async reset mid-load, then reload
      fw.delete();
      for (int i = 0; i < 3; i++) fw.push_back(rand_word());
      pulse_start();
      send_byte(8'd3, 0);
      send_byte(8'd0, 0);
      for (int i = 0; i < 6; i++) send_byte(8'(fw[i/4] >> (8 * (i % 4))), 0);
      #2 rst = 1'b1;
      #1;
      chk("t6_ready", 32'(rx_ready), 0);
      chk("t6_we",    32'(imem_we), 0);
      chk("t6_addr",  32'(imem_addr), 0);
      chk("t6_wdata", imem_wdata, 0);
      chk("t6_hold",  32'(cpu_hold), 1);
      chk("t6_done",  32'(done), 0);
      chk("t6_err",   32'(err), 0);
      chk("t6_words", 32'(words_rx), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      fw = '{rand_word()};
      pulse_start();
      base = wa.size();
      send_frame(1, 20);
      wait_end();
      check_writes("t6", base, 1);
      chk("t6_done2", 32'(done), 1);

      // 7: maximum-length program
      fw.delete();
      for (int i = 0; i < MAXW; i++) fw.push_back(rand_word());
      pulse_start();
      base = wa.size();
      send_frame(MAXW, 0);
      wait_end();
      check_writes("t7", base, MAXW);
      chk("t7_words", 32'(words_rx), 1024);
      chk("t7_addr", 32'(imem_addr), 1023);
      chk("t7_done", 32'(done), 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
